// File: rtl/scr1_pipe_mul_ctrl_pkg.sv
// Shared types for the multiplier sequencer: opcode and FSM encodings,
// operand width and the operand sign / cache class helpers.
package scr1_mul_pkg;

    localparam int SCR1_MUL_DIN_W = 33;

    typedef enum logic [1:0] {
        SCR1_MUL_OP_MUL    = 2'd0,
        SCR1_MUL_OP_MULH   = 2'd1,
        SCR1_MUL_OP_MULHSU = 2'd2,
        SCR1_MUL_OP_MULHU  = 2'd3
    } type_scr1_mul_op_e;

    typedef enum logic [2:0] {
        SCR1_MUL_FSM_IDLE,
        SCR1_MUL_FSM_START,
        SCR1_MUL_FSM_BUSY,
        SCR1_MUL_FSM_RESP,
        SCR1_MUL_FSM_DRAIN
    } type_scr1_mul_ctrl_fsm_e;

    // Operations with the same sign treatment produce the same 64-bit product
    typedef enum logic [1:0] {
        SCR1_MUL_CLS_UU,
        SCR1_MUL_CLS_SS,
        SCR1_MUL_CLS_SU
    } type_scr1_mul_cls_e;

    function automatic logic [1:0] scr1_mul_signs(input type_scr1_mul_op_e op,
                                                  input logic op1_msb,
                                                  input logic op2_msb);
        case (op)
            SCR1_MUL_OP_MULH:   return {op1_msb, op2_msb};
            SCR1_MUL_OP_MULHSU: return {op1_msb, 1'b0};
            default:            return 2'b00;
        endcase
    endfunction

    function automatic type_scr1_mul_cls_e scr1_mul_cls(input type_scr1_mul_op_e op);
        case (op)
            SCR1_MUL_OP_MULH:   return SCR1_MUL_CLS_SS;
            SCR1_MUL_OP_MULHSU: return SCR1_MUL_CLS_SU;
            default:            return SCR1_MUL_CLS_UU;
        endcase
    endfunction

endpackage

// File: rtl/scr1_pipe_mul_ctrl_if.sv
// EXU-side and multiplier-side signals of the multiply sequencer.
// slave: the controller; master: the EXU plus the multiplier around it.
interface scr1_pipe_mul_ctrl_if;
    import scr1_mul_pkg::*;

    logic                      exu_req_i;
    logic [1:0]                exu_op_i;
    logic [31:0]               exu_op1_i;
    logic [31:0]               exu_op2_i;
    logic                      exu_kill_i;
    logic                      exu_rdy_o;
    logic                      exu_res_vd_o;
    logic [31:0]               exu_res_o;
    logic                      exu_res_ack_i;
    logic                      err_o;
    logic [SCR1_MUL_DIN_W-1:0] mul_din1_o;
    logic [SCR1_MUL_DIN_W-1:0] mul_din2_o;
    logic                      mul_valid_o;
    logic [31:0]               mul_hi_i;
    logic [31:0]               mul_lo_i;
    logic                      mul_rdy_i;
    logic                      mul_done_o;

    modport slave (
        input  exu_req_i, exu_op_i, exu_op1_i, exu_op2_i, exu_kill_i, exu_res_ack_i,
        input  mul_hi_i, mul_lo_i, mul_rdy_i,
        output exu_rdy_o, exu_res_vd_o, exu_res_o, err_o,
        output mul_din1_o, mul_din2_o, mul_valid_o, mul_done_o
    );

    modport master (
        output exu_req_i, exu_op_i, exu_op1_i, exu_op2_i, exu_kill_i, exu_res_ack_i,
        output mul_hi_i, mul_lo_i, mul_rdy_i,
        input  exu_rdy_o, exu_res_vd_o, exu_res_o, err_o,
        input  mul_din1_o, mul_din2_o, mul_valid_o, mul_done_o
    );
endinterface

// File: rtl/scr1_pipe_mul_ctrl_res_cache.sv
// Single-entry cache of the last completed multiply (operands, sign class, 64-bit product).
// Only instantiated when SCR1_MUL_RES_CACHE_EN is defined.
module scr1_mul_res_cache
    import scr1_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  type_scr1_mul_op_e lk_op,
    input  logic [31:0]       lk_op1,
    input  logic [31:0]       lk_op2,
    output logic              lk_hit,
    output logic [31:0]       lk_res,
    input  logic              wr_en,
    input  type_scr1_mul_op_e wr_op,
    input  logic [31:0]       wr_op1,
    input  logic [31:0]       wr_op2,
    input  logic [31:0]       wr_hi,
    input  logic [31:0]       wr_lo
);
    logic               vld_reg;
    type_scr1_mul_cls_e cls_reg;
    logic [31:0]        op1_reg;
    logic [31:0]        op2_reg;
    logic [31:0]        hi_reg;
    logic [31:0]        lo_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_reg <= 1'b0;
            cls_reg <= SCR1_MUL_CLS_UU;
            op1_reg <= '0;
            op2_reg <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
        end else if (wr_en) begin
            vld_reg <= 1'b1;
            cls_reg <= scr1_mul_cls(wr_op);
            op1_reg <= wr_op1;
            op2_reg <= wr_op2;
            hi_reg  <= wr_hi;
            lo_reg  <= wr_lo;
        end
    end

    assign lk_hit = vld_reg && (cls_reg == scr1_mul_cls(lk_op))
                 && (op1_reg == lk_op1) && (op2_reg == lk_op2);
    assign lk_res = (lk_op == SCR1_MUL_OP_MUL) ? lo_reg : hi_reg;

endmodule

// File: rtl/scr1_pipe_mul_ctrl.sv
// Sequencer between the EXU and the iterative multiplier: operand build, handshake,
// kill/drain and hang watchdog. Optional result cache: SCR1_MUL_RES_CACHE_EN.
module scr1_pipe_mul_ctrl
    import scr1_mul_pkg::*;
#(
    parameter int WDT_CYCLES = 31
) (
    input  logic                clk,
    input  logic                rstn,
    scr1_pipe_mul_ctrl_if.slave bus
);
    localparam bit             WDT_EN   = (WDT_CYCLES > 0);
    localparam int             WDT_W    = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'((WDT_CYCLES > 0) ? WDT_CYCLES - 1 : 0);

    type_scr1_mul_ctrl_fsm_e   state_reg, state_next;
    type_scr1_mul_op_e         op_reg, op_next, req_op;
    logic [SCR1_MUL_DIN_W-1:0] din1_reg, din1_next, din2_reg, din2_next;
    logic [31:0]               res_reg, res_next;
    logic [WDT_W-1:0]          wdt_cnt_reg, wdt_cnt_next;
    logic                      err_reg, err_next;
    logic [1:0]                req_signs;
    logic                      wdt_hit;
    logic                      cache_hit, cache_wr;
    logic [31:0]               cache_res;
    logic                      rdy, res_vd, mul_valid, mul_done;

    assign req_op    = type_scr1_mul_op_e'(bus.exu_op_i);
    assign req_signs = scr1_mul_signs(req_op, bus.exu_op1_i[31], bus.exu_op2_i[31]);
    assign wdt_hit   = WDT_EN && (wdt_cnt_reg == WDT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= SCR1_MUL_FSM_IDLE;
            op_reg      <= SCR1_MUL_OP_MUL;
            din1_reg    <= '0;
            din2_reg    <= '0;
            res_reg     <= '0;
            wdt_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            din1_reg    <= din1_next;
            din2_reg    <= din2_next;
            res_reg     <= res_next;
            wdt_cnt_reg <= wdt_cnt_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        din1_next    = din1_reg;
        din2_next    = din2_reg;
        res_next     = res_reg;
        err_next     = err_reg;
        wdt_cnt_next = '0;
        rdy          = 1'b0;
        res_vd       = 1'b0;
        mul_valid    = 1'b0;
        mul_done     = 1'b0;
        cache_wr     = 1'b0;
        case (state_reg)
            SCR1_MUL_FSM_IDLE: begin
                rdy = 1'b1;
                if (bus.exu_req_i && !bus.exu_kill_i) begin
                    op_next   = req_op;
                    din1_next = {req_signs[1], bus.exu_op1_i};
                    din2_next = {req_signs[0], bus.exu_op2_i};
                    if (cache_hit) begin
                        res_next   = cache_res;
                        state_next = SCR1_MUL_FSM_RESP;
                    end else begin
                        state_next = SCR1_MUL_FSM_START;
                    end
                end
            end
            SCR1_MUL_FSM_START: begin
                // The multiplier is committed once valid is issued, so a kill must drain it
                mul_valid  = 1'b1;
                state_next = bus.exu_kill_i ? SCR1_MUL_FSM_DRAIN : SCR1_MUL_FSM_BUSY;
            end
            SCR1_MUL_FSM_BUSY: begin
                if (bus.mul_rdy_i) begin
                    mul_done   = 1'b1;
                    cache_wr   = 1'b1;
                    res_next   = (op_reg == SCR1_MUL_OP_MUL) ? bus.mul_lo_i : bus.mul_hi_i;
                    state_next = bus.exu_kill_i ? SCR1_MUL_FSM_IDLE : SCR1_MUL_FSM_RESP;
                end else if (wdt_hit) begin
                    err_next   = 1'b1;
                    state_next = SCR1_MUL_FSM_IDLE;
                end else begin
                    wdt_cnt_next = wdt_cnt_reg + 1'b1;
                    if (bus.exu_kill_i) state_next = SCR1_MUL_FSM_DRAIN;
                end
            end
            SCR1_MUL_FSM_RESP: begin
                res_vd = 1'b1;
                if (bus.exu_res_ack_i || bus.exu_kill_i) state_next = SCR1_MUL_FSM_IDLE;
            end
            SCR1_MUL_FSM_DRAIN: begin
                if (bus.mul_rdy_i) begin
                    mul_done   = 1'b1;
                    state_next = SCR1_MUL_FSM_IDLE;
                end else if (wdt_hit) begin
                    err_next   = 1'b1;
                    state_next = SCR1_MUL_FSM_IDLE;
                end else begin
                    wdt_cnt_next = wdt_cnt_reg + 1'b1;
                end
            end
            default: state_next = SCR1_MUL_FSM_IDLE;
        endcase
    end

`ifdef SCR1_MUL_RES_CACHE_EN
    scr1_mul_res_cache i_res_cache (
        .clk    (clk),
        .rstn   (rstn),
        .lk_op  (req_op),
        .lk_op1 (bus.exu_op1_i),
        .lk_op2 (bus.exu_op2_i),
        .lk_hit (cache_hit),
        .lk_res (cache_res),
        .wr_en  (cache_wr),
        .wr_op  (op_reg),
        .wr_op1 (din1_reg[31:0]),
        .wr_op2 (din2_reg[31:0]),
        .wr_hi  (bus.mul_hi_i),
        .wr_lo  (bus.mul_lo_i)
    );
`else
    logic unused_cache_wr;
    assign unused_cache_wr = cache_wr;
    assign cache_hit       = 1'b0;
    assign cache_res       = '0;
`endif

    assign bus.exu_rdy_o    = rdy;
    assign bus.exu_res_vd_o = res_vd;
    assign bus.exu_res_o    = res_reg;
    assign bus.err_o        = err_reg;
    assign bus.mul_din1_o   = din1_reg;
    assign bus.mul_din2_o   = din2_reg;
    assign bus.mul_valid_o  = mul_valid;
    assign bus.mul_done_o   = mul_done;

endmodule

// File: doc/scr1_pipe_mul_ctrl.md
Name: scr1_pipe_mul_ctrl

Overview:
- Sequencer between the EXU and the 8-stage iterative multiplier `scr1_pipe_mul`.
- Accepts RV32M MUL/MULH/MULHSU/MULHU requests and builds the 33-bit sign-tagged operands.
- Runs the multiplier's valid/ready/done handshake, selects the high or low product word, and holds the result until the EXU acknowledges it.
- Handles EXU kill during a multiply, and flags a multiplier hang with a watchdog.

Parameters:
WDT_CYCLES, 31, max cycles in BUSY waiting for mul_rdy_i before err_o; 0 disables the watchdog

Ports:
clk  in  1  core clock
rstn  in  1  async active-low reset
exu_req_i  in  1  new multiply request (sampled only when exu_rdy_o=1)
exu_op_i  in  2  0=MUL 1=MULH 2=MULHSU 3=MULHU
exu_op1_i  in  32  rs1 value
exu_op2_i  in  32  rs2 value
exu_kill_i  in  1  pipeline flush; abandon current request
exu_rdy_o  out  1  controller idle, can accept a request
exu_res_vd_o  out  1  result valid, held until ack
exu_res_o  out  32  selected product word
exu_res_ack_i  in  1  EXU consumed result
err_o  out  1  sticky watchdog error
mul_din1_o  out  33  {sign,op1} to multiplier Din1
mul_din2_o  out  33  {sign,op2} to multiplier Din2
mul_valid_o  out  1  multiplier data_valid
mul_hi_i  in  32  multiplier des_hig
mul_lo_i  in  32  multiplier des_low
mul_rdy_i  in  1  multiplier result-ready pulse
mul_done_o  out  1  multiplier data_done

Behaviour:
- Reset values: all outputs 0 except exu_rdy_o=1. State returns to IDLE; the watchdog counter clears.
- States and transitions:
  - IDLE: exu_rdy_o=1. On exu_req_i & !exu_kill_i, register op, din1, din2 -> START.
  - START: mul_valid_o=1 for exactly one cycle -> BUSY.
  - BUSY: wait for mul_rdy_i. On it, capture hi/lo into the result register -> RESP, and pulse mul_done_o in the same cycle.
  - RESP: exu_res_vd_o=1 until exu_res_ack_i. On ack -> IDLE next cycle.
- Operand signs: MUL bit32=0/0; MULH op1[31]/op2[31]; MULHSU op1[31]/0; MULHU 0/0. Bits [31:0] pass through unchanged.
- mul_din1_o/mul_din2_o are registered and held stable from START through the mul_rdy_i cycle. The multiplier reads the sign bits again in its final state.
- Result select: MUL -> lo, others -> hi. exu_res_o is stable while exu_res_vd_o=1.
- mul_done_o: asserted only in the cycle mul_rdy_i is seen (also in DRAIN). Since mul_rdy_i is a one-cycle pulse, mul_done_o is too.
- Kill:
  - In IDLE or START: the request is dropped. In START, mul_valid_o is still issued (the operation is already committed), then the controller enters DRAIN.
  - In BUSY: enter DRAIN.
  - In RESP: drop the result and go to IDLE.
  - DRAIN: wait for mul_rdy_i, pulse mul_done_o, no exu_res_vd_o -> IDLE. exu_rdy_o=0 throughout DRAIN.
- Kill and ack in the same cycle in RESP: ack wins, and the result counts as consumed.
- Watchdog: counts BUSY/DRAIN cycles. When it reaches WDT_CYCLES: err_o=1 (sticky until reset) and force IDLE.
- Reset mid-operation: the controller and multiplier share rstn, so both return to idle together. No partial state is retained.
- Latency from request to exu_res_vd_o: fixed by the multiplier, 12 cycles with the current multiplier; must be <=16.

Optional Feature:
SCR1_MUL_RES_CACHE_EN:
- Defined:
  - Stores the last completed {op1, op2, signed-pair class} and its 64-bit product.
  - Signed-pair class: MUL/MULHU share the unsigned class; MULH and MULHSU are distinct.
  - A request matching the stored entry (e.g. MULHU followed by MUL on the same registers) goes IDLE -> RESP next cycle, with no multiplier activity.
  - Kill invalidates nothing; reset invalidates the entry.
- Undefined: every request uses the multiplier; no storage is added.

Decomposition:
- Package `scr1_mul_pkg`:
  - type_scr1_mul_op_e (MUL/MULH/MULHSU/MULHU encodings).
  - type_scr1_mul_ctrl_fsm_e (IDLE, START, BUSY, RESP, DRAIN).
  - SCR1_MUL_DIN_W=33.
- Optional sub-module `scr1_mul_res_cache`: the compare/store logic, instantiated only under SCR1_MUL_RES_CACHE_EN.

Test Plan:
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> exu_res_o=0xFFFFFFFE, mul_din1_o[32]=0, response within 16 cycles, one mul_done_o pulse.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- MUL 0x12345678 x 0x00000010 -> 0x23456780. Hold ack low 5 cycles -> exu_res_vd_o and exu_res_o stay stable; exu_rdy_o=0 until the cycle after ack.
- Kill 3 cycles after accept -> no exu_res_vd_o, mul_done_o pulses on mul_rdy_i, exu_rdy_o=1 after drain; the next MUL 3x5 returns 15.
- Stub multiplier never asserting mul_rdy_i -> err_o=1 after 31 BUSY cycles, controller returns to IDLE.
- With SCR1_MUL_RES_CACHE_EN: MULHU 0xFFFFFFFF,0xFFFFFFFF then MUL on the same operands -> second result 0x00000001 one cycle after accept, mul_valid_o not asserted.
